lcd_cmd_seq: RTL and testbench



---
 rtl/lcd_pkg.sv | 29 ++
 rtl/lcd_cmd_fifo.sv | 69 ++++++
 rtl/lcd_cmd_seq.sv | 152 +++++++++++++++
 tb/tb_lcd_cmd_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared command codes, FSM state encoding and command width for the LCD
// command sequencer.
package lcd_pkg;

  localparam int CMD_W = 4;

  localparam logic [CMD_W-1:0] CMD_WRITE   = 4'h0;
  localparam logic [CMD_W-1:0] SHIFT_UP    = 4'h1;
  localparam logic [CMD_W-1:0] SHIFT_DOWN  = 4'h2;
  localparam logic [CMD_W-1:0] SHIFT_LEFT  = 4'h3;
  localparam logic [CMD_W-1:0] SHIFT_RIGHT = 4'h4;
  localparam logic [CMD_W-1:0] MAX         = 4'h5;
  localparam logic [CMD_W-1:0] MIN         = 4'h6;
  localparam logic [CMD_W-1:0] AVG         = 4'h7;
  localparam logic [CMD_W-1:0] ROT_CCW     = 4'h8;
  localparam logic [CMD_W-1:0] ROT_CW      = 4'h9;
  localparam logic [CMD_W-1:0] MIRROR_X    = 4'hA;
  localparam logic [CMD_W-1:0] MIRROR_Y    = 4'hB;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_RDY  = 3'd1,
    ISSUE     = 3'd2,
    GAP       = 3'd3,
    WAIT_DONE = 3'd4,
    FINISH    = 3'd5
  } seq_state_e;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags and a sticky overflow flag.
// A push that coincides with a pop is accepted even when full.
module lcd_cmd_fifo #(
  parameter int CMD_W = 4,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [CMD_W-1:0] wdata,
  input  logic             pop,
  output logic [CMD_W-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             do_push, do_pop;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign overflow = overflow_q;
  assign rdata    = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || (push && !do_push);
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/lcd_cmd_seq.sv
// LCD command sequencer: issues queued commands under the controller's busy
// handshake. Define LCD_SEQ_TIMEOUT_EN to build the busy/done watchdog.
module lcd_cmd_seq
  import lcd_pkg::*;
#(
  parameter int CMD_W   = lcd_pkg::CMD_W,
  parameter int DEPTH   = 64,
  parameter int CNT_W   = 7,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             host_wr,
  input  logic [CMD_W-1:0] host_cmd,
  input  logic             start,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             overflow,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_valid,
  input  logic             busy,
  input  logic             done,
  output logic [CNT_W-1:0] issued_cnt,
  output logic             finish,
  output logic             timeout_err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("lcd_cmd_seq: TIMEOUT must be at least 1");
  end

  seq_state_e       state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [CNT_W-1:0] issued_cnt_q, issued_cnt_d;
  logic             finish_q, finish_d;
  logic             fifo_pop;
  logic [CMD_W-1:0] fifo_rdata;

  lcd_cmd_fifo #(
    .CMD_W (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (host_wr),
    .wdata    (host_cmd),
    .pop      (fifo_pop),
    .rdata    (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (overflow)
  );

`ifdef LCD_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_err_q, timeout_err_d;
  logic            stall;

  assign stall       = ((state_q == WAIT_RDY) && busy) || ((state_q == WAIT_DONE) && !done);
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cmd_valid_d  = 1'b0;
    issued_cnt_d = issued_cnt_q;
    finish_d     = finish_q;
    fifo_pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = WAIT_RDY;
          issued_cnt_d = '0;
          finish_d     = 1'b0;
        end
      end
      WAIT_RDY: begin
        if (!busy && !fifo_empty) begin
          fifo_pop    = 1'b1;
          cmd_d       = fifo_rdata;
          cmd_valid_d = 1'b1;
          state_d     = ISSUE;
          if (issued_cnt_q != {CNT_W{1'b1}}) issued_cnt_d = issued_cnt_q + 1'b1;
        end
      end
      ISSUE:     state_d = (cmd_q == CMD_W'(CMD_WRITE)) ? WAIT_DONE : GAP;
      // GAP hides the controller's stale busy=0 for one cycle.
      GAP:       state_d = WAIT_RDY;
      WAIT_DONE: begin
        if (done) begin
          state_d  = FINISH;
          finish_d = 1'b1;
        end
      end
      FINISH: begin
        if (start) begin
          state_d      = WAIT_RDY;
          issued_cnt_d = '0;
          finish_d     = 1'b0;
        end
      end
      default:   state_d = IDLE;
    endcase
`ifdef LCD_SEQ_TIMEOUT_EN
    to_cnt_d      = '0;
    timeout_err_d = timeout_err_q;
    if (stall) begin
      if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
        timeout_err_d = 1'b1;
        state_d       = IDLE;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      cmd_valid_q  <= 1'b0;
      issued_cnt_q <= '0;
      finish_q     <= 1'b0;
`ifdef LCD_SEQ_TIMEOUT_EN
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cmd_valid_q  <= cmd_valid_d;
      issued_cnt_q <= issued_cnt_d;
      finish_q     <= finish_d;
`ifdef LCD_SEQ_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign cmd        = cmd_q;
  assign cmd_valid  = cmd_valid_q;
  assign issued_cnt = issued_cnt_q;
  assign finish     = finish_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Directed self-checking bench for lcd_cmd_seq (default and LCD_SEQ_TIMEOUT_EN builds).
module tb_lcd_cmd_seq;
  import lcd_pkg::*;

  localparam int TB_CMD_W = 4;
  localparam int TB_CNT_W = 7;
`ifdef LCD_SEQ_TIMEOUT_EN
  localparam int BUSY_HOLD = 10;
`else
  localparam int BUSY_HOLD = 20;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                host_wr;
  logic [TB_CMD_W-1:0] host_cmd;
  logic                start;
  logic                fifo_full, fifo_empty, overflow;
  logic [TB_CMD_W-1:0] cmd;
  logic                cmd_valid;
  logic                busy, done;
  logic [TB_CNT_W-1:0] issued_cnt;
  logic                finish;
  logic                timeout_err;

  int n_chk  = 0;
  int n_fail = 0;

  lcd_cmd_seq #(
    .CMD_W   (TB_CMD_W),
    .DEPTH   (64),
    .CNT_W   (TB_CNT_W),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .host_wr     (host_wr),
    .host_cmd    (host_cmd),
    .start       (start),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .overflow    (overflow),
    .cmd         (cmd),
    .cmd_valid   (cmd_valid),
    .busy        (busy),
    .done        (done),
    .issued_cnt  (issued_cnt),
    .finish      (finish),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] v);
    host_wr  = 1'b1;
    host_cmd = v;
    tick();
    host_wr  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [3:0] sv [4];
    int         sk [4];
    int         ns;
    int         nv;
    int         idx;
    int         extra;
    logic [3:0] exp_q [64];

    reset = 1'b1; host_wr = 1'b0; host_cmd = '0; start = 1'b0; busy = 1'b0; done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_cmd", 32'(cmd), 0);
    chk("rst_fifo_empty", 32'(fifo_empty), 1);
    chk("rst_fifo_full", 32'(fifo_full), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_issued_cnt", 32'(issued_cnt), 0);
    chk("rst_finish", 32'(finish), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));

    // Four commands, controller always ready.
    push(4'h1); push(4'h4); push(4'h5); push(4'h0);
    pulse_start();
    chk("t1_state_after_start", 32'(dut.state_q), 32'(WAIT_RDY));
    ns = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (cmd_valid) begin
        if (ns < 4) begin
          sv[ns] = cmd;
          sk[ns] = k;
        end
        ns++;
      end
    end
    chk("t1_strobe_count", 32'(ns), 4);
    chk("t1_cmd0", 32'(sv[0]), 32'h1);
    chk("t1_cmd1", 32'(sv[1]), 32'h4);
    chk("t1_cmd2", 32'(sv[2]), 32'h5);
    chk("t1_cmd3", 32'(sv[3]), 32'h0);
    chk("t1_first_cycle", 32'(sk[0]), 1);
    chk("t1_space01", 32'(sk[1] - sk[0]), 3);
    chk("t1_space12", 32'(sk[2] - sk[1]), 3);
    chk("t1_space23", 32'(sk[3] - sk[2]), 3);
    chk("t1_issued_cnt", 32'(issued_cnt), 4);
    chk("t1_state_wait_done", 32'(dut.state_q), 32'(WAIT_DONE));
    chk("t1_finish_before_done", 32'(finish), 0);
    done = 1'b1; tick(); done = 1'b0;
    chk("t1_finish", 32'(finish), 1);
    chk("t1_state_finish", 32'(dut.state_q), 32'(FINISH));

    // Busy holds off issue.
    push(4'h3); push(4'h0);
    busy = 1'b1;
    pulse_start();
    chk("t2_finish_cleared", 32'(finish), 0);
    chk("t2_cnt_cleared", 32'(issued_cnt), 0);
    nv = 0;
    for (int k = 0; k < BUSY_HOLD; k++) begin
      tick();
      if (cmd_valid) nv++;
    end
    chk("t2_no_valid_while_busy", 32'(nv), 0);
    busy = 1'b0;
    tick();
    chk("t2_valid_3", 32'(cmd_valid), 1);
    chk("t2_cmd_3", 32'(cmd), 32'h3);
    busy = 1'b1;
    nv = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (cmd_valid) nv++;
    end
    chk("t2_no_valid_busy5", 32'(nv), 0);
    busy = 1'b0;
    tick();
    chk("t2_valid_0", 32'(cmd_valid), 1);
    chk("t2_cmd_0", 32'(cmd), 32'h0);
    chk("t2_issued_cnt", 32'(issued_cnt), 2);
    tick();
    chk("t2_valid_low", 32'(cmd_valid), 0);
    chk("t2_cmd_hold", 32'(cmd), 32'h0);
    chk("t2_state_wait_done", 32'(dut.state_q), 32'(WAIT_DONE));
    done = 1'b1; tick(); done = 1'b0;
    chk("t2_finish", 32'(finish), 1);

    // Fill, overflow, push+pop while full, then drain in order.
    for (int i = 0; i < 64; i++) begin
      exp_q[i] = 4'((i % 11) + 1);
      push(exp_q[i]);
    end
    chk("t3_full", 32'(fifo_full), 1);
    chk("t3_no_overflow_yet", 32'(overflow), 0);
    push(4'hE);
    chk("t3_full_after_65", 32'(fifo_full), 1);
    chk("t3_overflow", 32'(overflow), 1);
    pulse_start();
    chk("t3_state_wait_rdy", 32'(dut.state_q), 32'(WAIT_RDY));
    push(4'hD);
    chk("t3_full_push_pop", 32'(fifo_full), 1);
    chk("t3_first_valid", 32'(cmd_valid), 1);
    chk("t3_first_cmd", 32'(cmd), 32'h1);
    chk("t3_overflow_sticky", 32'(overflow), 1);
    for (int i = 0; i < 63; i++) exp_q[i] = exp_q[i + 1];
    exp_q[63] = 4'hD;
    idx = 0;
    extra = 0;
    for (int k = 0; k < 250; k++) begin
      tick();
      if (cmd_valid) begin
        if (idx < 64) begin
          chk($sformatf("t3_drain_%0d", idx), 32'(cmd), 32'(exp_q[idx]));
          idx++;
        end else begin
          extra++;
        end
      end
    end
    chk("t3_drain_count", 32'(idx + extra), 64);
    chk("t3_issued_cnt", 32'(issued_cnt), 65);
    chk("t3_empty", 32'(fifo_empty), 1);
    chk("t3_state_wait_rdy_empty", 32'(dut.state_q), 32'(WAIT_RDY));

    // Empty FIFO, late push.
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (cmd_valid) nv++;
    end
    chk("t4_no_valid_empty", 32'(nv), 0);
    push(4'h7);
    chk("t4_no_valid_push_cycle", 32'(cmd_valid), 0);
    tick();
    chk("t4_valid", 32'(cmd_valid), 1);
    chk("t4_cmd", 32'(cmd), 32'h7);
    chk("t4_issued_cnt", 32'(issued_cnt), 66);

    // Reset during the second of three issues.
    reset = 1'b1; tick(); reset = 1'b0;
    push(4'h2); push(4'h3); push(4'h4);
    pulse_start();
    for (int k = 0; k < 4; k++) tick();
    chk("t5_valid_2nd", 32'(cmd_valid), 1);
    chk("t5_cmd_2nd", 32'(cmd), 32'h3);
    chk("t5_state_issue", 32'(dut.state_q), 32'(ISSUE));
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t5_valid_cleared", 32'(cmd_valid), 0);
    chk("t5_empty", 32'(fifo_empty), 1);
    chk("t5_issued_cnt", 32'(issued_cnt), 0);
    chk("t5_state_idle", 32'(dut.state_q), 32'(IDLE));

    // Busy held indefinitely.
    busy = 1'b1;
    pulse_start();
`ifdef LCD_SEQ_TIMEOUT_EN
    for (int k = 0; k < 15; k++) tick();
    chk("t6_no_timeout_15", 32'(timeout_err), 0);
    chk("t6_state_wait_15", 32'(dut.state_q), 32'(WAIT_RDY));
    tick();
    chk("t6_timeout_16", 32'(timeout_err), 1);
    chk("t6_state_idle", 32'(dut.state_q), 32'(IDLE));
    busy = 1'b0;
    pulse_start();
    tick();
    chk("t6_timeout_sticky", 32'(timeout_err), 1);
`else
    for (int k = 0; k < 40; k++) tick();
    chk("t6_no_timeout", 32'(timeout_err), 0);
    chk("t6_state_still_wait", 32'(dut.state_q), 32'(WAIT_RDY));
    busy = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
